// File: rtl/key_note_seq.sv
// key_note_seq: keypad synchroniser, debouncer and note encoder, with a
// DEPTH-entry record/playback buffer of timed notes driving the tone generator.
module key_note_seq #(
    parameter int DEB_CYCLES = 16,
    parameter int DEPTH      = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DIN,
    input  logic       REC,
    input  logic       PLAY,
    input  logic       TICK,
    output logic [3:0] KEY,
    output logic       BUSY,
    output logic       FULL,
    output logic [4:0] CNT
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(DEB_CYCLES) + 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(DEB_CYCLES - 2);
    localparam logic [4:0]    CNT_MAX  = 5'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RECORD, ST_PLAY} state_t;

    state_t        state, state_nx;
    logic [7:0]    sync1, sync2;
    logic [3:0]    code_raw, code_q, dcode;
    logic [SW-1:0] stab;
    logic          seg_open;
    logic [3:0]    seg_code, seg_dur, dur_inc, dur_wr;
    logic [4:0]    cnt, cnt_nx, idx, idx_nx;
    logic [3:0]    ptick, cur_dur;
    logic          entry_done, last_entry, wr_en;
    logic [3:0]    key_nx;
    logic          busy_nx;
    logic [3:0]    mem_code [DEPTH];
    logic [3:0]    mem_dur  [DEPTH];

    assign CNT = cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= DIN;
            sync2 <= sync1;
        end
    end

    always_comb begin
        code_raw = '0;
        if (sync2 == 8'h3F) begin
            code_raw = 4'd9;
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (sync2 == ~(8'b1 << i)) code_raw = 4'(i + 1);
            end
        end
    end

    // dcode loads on the DEB_CYCLES-th consecutive cycle the decoded code is unchanged
    always_ff @(posedge CLK) begin
        if (RST) begin
            code_q <= '0;
            stab   <= '0;
            dcode  <= '0;
        end else begin
            code_q <= code_raw;
            if (code_raw != code_q) begin
                stab <= '0;
            end else if (stab < STAB_MAX) begin
                stab <= stab + SW'(1);
            end else begin
                dcode <= code_raw;
            end
        end
    end

    always_comb begin
        dur_inc    = (seg_dur == 4'd15) ? 4'd15 : seg_dur + {3'b000, TICK};
        dur_wr     = (dur_inc == 4'd0) ? 4'd1 : dur_inc;
        cur_dur    = mem_dur[idx[IW-1:0]];
        entry_done = TICK && ((ptick + 4'd1) == cur_dur);
        last_entry = (idx == cnt - 5'd1);
        wr_en      = 1'b0;
        if (state == ST_RECORD && cnt != CNT_MAX) begin
            wr_en = REC ? (seg_open && dcode != seg_code)
                        : (seg_open && seg_code != 4'd0);
        end
        cnt_nx = cnt;
        if (state == ST_IDLE && REC) cnt_nx = '0;
        else if (wr_en)              cnt_nx = cnt + 5'd1;
        idx_nx = idx;
        if (state != ST_PLAY)   idx_nx = '0;
        else if (entry_done)    idx_nx = idx + 5'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (REC)                      state_nx = ST_RECORD;
                else if (PLAY && cnt != 5'd0) state_nx = ST_PLAY;
            end
            ST_RECORD: if (!REC) state_nx = ST_IDLE;
            ST_PLAY:   if (entry_done && last_entry) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // outputs are computed from the next state so KEY/BUSY switch on the sampling edge
    always_comb begin
        busy_nx = (state_nx == ST_PLAY);
        key_nx  = busy_nx ? mem_code[idx_nx[IW-1:0]] : dcode;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            KEY      <= '0;
            BUSY     <= 1'b0;
            FULL     <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            ptick    <= '0;
            seg_open <= 1'b0;
            seg_code <= '0;
            seg_dur  <= '0;
        end else begin
            KEY  <= key_nx;
            BUSY <= busy_nx;
            FULL <= (cnt_nx == CNT_MAX);
            cnt  <= cnt_nx;
            idx  <= idx_nx;
            if (state != ST_PLAY)  ptick <= '0;
            else if (TICK)         ptick <= entry_done ? 4'd0 : ptick + 4'd1;
            if (state == ST_RECORD && REC) begin
                if (!seg_open) begin
                    if (dcode != 4'd0) begin
                        seg_open <= 1'b1;
                        seg_code <= dcode;
                        seg_dur  <= '0;
                    end
                end else if (dcode != seg_code) begin
                    seg_code <= dcode;
                    seg_dur  <= '0;
                end else begin
                    seg_dur <= dur_inc;
                end
            end else begin
                seg_open <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_code[cnt[IW-1:0]] <= seg_code;
            mem_dur[cnt[IW-1:0]]  <= dur_wr;
        end
    end

endmodule

// File: doc/key_note_seq.md
# key_note_seq

Record/playback controller for the keypad music path. It sits between the 8-key active-low keypad bus and the tone generator. It synchronises and debounces the keys, encodes them to a 4-bit note code, and passes that code live to the tone generator. It can also record up to DEPTH notes with their durations into an internal buffer and play the sequence back on the same note-code output.

## Interface
- DEB_CYCLES, 16: consecutive CLK cycles a decoded key code must be stable before it is accepted (≥2).
- DEPTH, 16: note buffer entries (power of two, ≤16).
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- DIN  in  8  raw keypad lines, active-low, asynchronous to CLK.
- REC  in  1  record enable (level).
- PLAY  in  1  playback start; sampled in IDLE only.
- TICK  in  1  one-CLK-cycle note-time strobe (duration unit).
- KEY  out  4  note code to tone generator; 0 = silence.
- BUSY  out  1  high while in PLAY.
- FULL  out  1  high while stored count == DEPTH.
- CNT  out  5  number of stored entries.

## Operation
- Sync: DIN passes through a two-flop synchroniser. Both stages reset to 8'hFF.
- Decode of the synchronised bus:
  - Exactly one bit low: bit i gives code i+1, so 8'hFE→1 … 8'h7F→8.
  - 8'h3F gives 9.
  - Any other pattern, including 8'hFF, gives 0.
- Debounce:
  - A stability counter clears whenever the decoded code differs from its previous cycle.
  - The debounced code `dcode` loads the decoded code once it has been stable for DEB_CYCLES cycles.
- State IDLE:
  - KEY = dcode.
  - REC=1 → RECORD; the buffer is cleared (CNT=0) on entry.
  - Otherwise, PLAY=1 and CNT>0 → PLAY.
  - REC and PLAY both high: REC wins.
- State RECORD:
  - KEY = dcode.
  - A segment opens at the first nonzero dcode. Earlier rests are not recorded.
  - Every later dcode change closes the open segment and opens a new one. Rests (code 0) are recorded as segments.
  - Closing a segment writes {code, dur}. dur = TICKs seen while the segment was open, saturating at 15; a value of 0 is stored as 1.
  - A TICK in the cycle a segment closes counts toward the closing segment.
  - When CNT==DEPTH, writes are dropped and CNT holds.
  - REC=0 closes the open segment, unless it is a rest or no segment is open; either of those is discarded. State then goes to IDLE.
- State PLAY:
  - BUSY=1. Keys, REC and PLAY are ignored. Entries are read from index 0 upward.
  - KEY = entry code, held until the entry's dur-th TICK.
  - After the last entry's dur-th TICK, state goes to IDLE.
  - The buffer is preserved, so playback is repeatable.
- Reset: KEY=0, BUSY=0, FULL=0, CNT=0, dcode=0, state IDLE. Reset mid-RECORD or mid-PLAY aborts immediately and discards buffer contents.

## Timing
- Live latency: a DIN change that then stays stable appears on KEY exactly DEB_CYCLES+3 cycles later.
- Segment write: occurs in the cycle after dcode changes or REC is sampled low. CNT and FULL update in that same cycle.
- PLAY is sampled at edge n, giving BUSY=1 and KEY=entry0 from n+1.
- Entry k's dur-th TICK is sampled at edge m, giving KEY=entry k+1 from m+1.
- After the last entry, IDLE begins at m+1 with BUSY=0 and KEY=dcode.
- All outputs are registered.

## Test plan
- Reset, DIN=8'hFF → KEY=0, BUSY=0, FULL=0, CNT=0. Then DIN=8'hFB stable → KEY=3 exactly DEB_CYCLES+3 cycles later.
- Bounce: DIN toggles 8'hFE/8'hFF every 5 cycles (DEB_CYCLES=16) → KEY stays 0. After the bouncing stops at 8'hFE → KEY=1 after 19 cycles.
- Record: REC=1, then key 1 for 3 TICKs, release for 2 TICKs, DIN=8'h3F for 20 TICKs, REC=0 → CNT=3, entries {1,3},{0,2},{9,15}.
- Playback of that buffer: PLAY pulse → BUSY=1; KEY=1 for 3 TICKs, 0 for 2 TICKs, 9 for 15 TICKs. BUSY=0 the cycle after the 20th TICK.
- Overflow: record 18 alternating key segments with DEPTH=16 → CNT=16, FULL=1. Playback yields exactly 16 entries.
- RST asserted during PLAY at entry 2 → next cycle BUSY=0, KEY=0, CNT=0. A subsequent PLAY pulse is ignored.
